// File: rtl/sudoku_pkg.sv
// Shared definitions for the Sudoku board checker: default geometry,
// RAM row word layout and the scan FSM state encoding.
package sudoku_pkg;

    // Default geometry: 4x4 board built from 2x2 boxes, 4-bit digits.
    localparam int N_DEF   = 4;
    localparam int BOX_DEF = 2;
    localparam int DW_DEF  = 4;
    localparam int AW_DEF  = 2;

    // Scan sequencer states.
    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_FLUSH
    } state_t;

    // RAM row word layout: {writeProtect[N], blank[N], digits[N*DW]}.
    function automatic int ram_width(input int n, input int dw);
        return 2 * n + n * dw;
    endfunction

    function automatic int blank_lsb(input int n, input int dw);
        return n * dw;
    endfunction

    function automatic int wp_lsb(input int n, input int dw);
        return n * dw + n;
    endfunction

endpackage

// File: rtl/sudoku_digit_onehot.sv
// Per-cell decoder: turns one stored digit plus its blank bit into a
// one-hot "digit seen" mask and an out-of-range flag. Blank cells
// contribute nothing, so they never take part in duplicate or range checks.
module sudoku_digit_onehot
    import sudoku_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0] digit,
    input  logic          blank,
    output logic [N-1:0]  mask,
    output logic          range_err
);

    localparam logic [DW-1:0] MAX_DIGIT = DW'(N);

    // Decode digit d in 1..N to mask bit d-1; anything else is a range error.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch can be inferred.
        mask      = '0;
        range_err = 1'b0;
        for (int i = 0; i < N; i++) begin
            mask[i] = !blank && (digit == DW'(i + 1));
        end
        range_err = !blank && ((digit == '0) || (digit > MAX_DIGIT));
    end

endmodule

// File: rtl/sudoku_board_checker.sv
// Full-board Sudoku validator. On a start request it walks the game RAM one
// row per cycle, checking rows, columns and boxes for duplicates, blank
// cells and out-of-range digits, then publishes gameComplete/boardValid
// with a one-cycle done pulse.
// Optional feature macro CHECKER_CONFLICT_LOC_EN adds conflictRow,
// conflictCol and conflictHit, locating the first duplicate in scan order.
module sudoku_board_checker
    import sudoku_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int BOX = BOX_DEF,
    parameter int DW  = DW_DEF,
    parameter int AW  = AW_DEF
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  start,
    output logic [AW-1:0]         RamAddr,
    input  logic [2*N+N*DW-1:0]   RamDat,
    output logic                  busy,
    output logic                  done,
    output logic                  gameComplete,
    output logic                  boardValid
`ifdef CHECKER_CONFLICT_LOC_EN
   ,output logic [AW-1:0]         conflictRow,
    output logic [AW-1:0]         conflictCol,
    output logic                  conflictHit
`endif
);

    localparam int             BLANK_LSB = blank_lsb(N, DW);
    localparam int             WP_LSB    = wp_lsb(N, DW);
    localparam logic [AW-1:0]  LAST_ROW  = AW'(N - 1);

    // Sequencer and pipeline registers.
    state_t        state, next_state;
    logic          chk_valid;      // RamDat holds a row to be checked this cycle
    logic [AW-1:0] chk_row;        // index of the row currently on RamDat

    // Accumulated "digit seen" masks and error flags for the running scan.
    logic [N-1:0]  col_seen [N];
    logic [N-1:0]  box_seen [BOX];
    logic          dup_acc, blank_acc, range_acc;

    // Per-cell decode of the row on RamDat.
    logic [N-1:0]  cell_mask [N];
    logic [N-1:0]  cell_range;
    logic [N-1:0]  cell_blank;
    logic [N-1:0]  cell_dup;

    // Combinational view of this row's contribution.
    logic          band_start;
    logic [N-1:0]  row_prefix;
    logic [N-1:0]  box_next [BOX];
    logic          row_dup, row_blank, row_range;
    logic          dup_total, blank_total, range_total;

    // Write-protect bits travel with the row but play no part in checking.
    logic          unused_wp;
    assign unused_wp  = ^RamDat[WP_LSB +: N];

    assign cell_blank = RamDat[BLANK_LSB +: N];

    genvar c;
    for (c = 0; c < N; c++) begin : g_cell
        sudoku_digit_onehot #(
            .N  (N),
            .DW (DW)
        ) u_digit (
            .digit     (RamDat[c*DW +: DW]),
            .blank     (cell_blank[c]),
            .mask      (cell_mask[c]),
            .range_err (cell_range[c])
        );
    end

    // A done cycle is still "busy"; busy drops the cycle after the pulse.
    assign busy = (state != S_IDLE) || done;

    // Next-state logic: start is honoured only when idle and not mid-pulse.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start && !done)      next_state = S_SCAN;
            S_SCAN:  if (RamAddr == LAST_ROW) next_state = S_FLUSH;
            S_FLUSH:                          next_state = S_IDLE;
            default:                          next_state = S_IDLE;
        endcase
    end

    // Row check: a cell is a duplicate if its digit already appeared earlier
    // in this row, earlier in its column, or earlier in its box band.
    always_comb begin
        band_start = (int'(chk_row) % BOX) == 0;
        row_prefix = '0;
        cell_dup   = '0;
        for (int b = 0; b < BOX; b++) begin
            box_next[b] = band_start ? '0 : box_seen[b];
        end
        for (int i = 0; i < N; i++) begin
            cell_dup[i]     = |(cell_mask[i] & (row_prefix | col_seen[i] | box_next[i / BOX]));
            row_prefix      = row_prefix | cell_mask[i];
            box_next[i / BOX] = box_next[i / BOX] | cell_mask[i];
        end
        row_dup     = |cell_dup;
        row_blank   = |cell_blank;
        row_range   = |cell_range;
        dup_total   = dup_acc   || (chk_valid && row_dup);
        blank_total = blank_acc || (chk_valid && row_blank);
        range_total = range_acc || (chk_valid && row_range);
    end

`ifdef CHECKER_CONFLICT_LOC_EN
    logic          conflict_found;
    logic [AW-1:0] conflict_row_acc, conflict_col_acc;
    logic [AW-1:0] first_col;
    logic [AW-1:0] final_row, final_col;

    // Locate the lowest duplicate column in this row and the scan-wide first hit.
    always_comb begin
        first_col = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cell_dup[i]) first_col = AW'(i);
        end
        final_row = '0;
        final_col = '0;
        if (conflict_found) begin
            final_row = conflict_row_acc;
            final_col = conflict_col_acc;
        end else if (chk_valid && row_dup) begin
            final_row = chk_row;
            final_col = first_col;
        end
    end
`endif

    // All sequential state: sequencer, address, masks, flags and results.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= S_IDLE;
            RamAddr      <= '0;
            chk_valid    <= 1'b0;
            chk_row      <= '0;
            done         <= 1'b0;
            gameComplete <= 1'b0;
            boardValid   <= 1'b0;
            dup_acc      <= 1'b0;
            blank_acc    <= 1'b0;
            range_acc    <= 1'b0;
            // NOTE: the mask arrays are a handful of flops, not a RAM, so they take the async reset like everything else.
            for (int i = 0; i < N; i++)   col_seen[i] <= '0;
            for (int b = 0; b < BOX; b++) box_seen[b] <= '0;
`ifdef CHECKER_CONFLICT_LOC_EN
            conflict_found   <= 1'b0;
            conflict_row_acc <= '0;
            conflict_col_acc <= '0;
            conflictRow      <= '0;
            conflictCol      <= '0;
            conflictHit      <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments here so every register samples the pre-edge values.
            state     <= next_state;
            done      <= 1'b0;
            chk_valid <= (state == S_SCAN);
            chk_row   <= RamAddr;

            case (state)
                S_IDLE: begin
                    if (next_state == S_SCAN) begin
                        RamAddr   <= '0;
                        dup_acc   <= 1'b0;
                        blank_acc <= 1'b0;
                        range_acc <= 1'b0;
                        for (int i = 0; i < N; i++)   col_seen[i] <= '0;
                        for (int b = 0; b < BOX; b++) box_seen[b] <= '0;
`ifdef CHECKER_CONFLICT_LOC_EN
                        conflict_found   <= 1'b0;
                        conflict_row_acc <= '0;
                        conflict_col_acc <= '0;
`endif
                    end
                end
                S_SCAN: begin
                    if (RamAddr != LAST_ROW) RamAddr <= RamAddr + AW'(1);
                end
                default: ;
            endcase

            if (chk_valid) begin
                for (int i = 0; i < N; i++)   col_seen[i] <= col_seen[i] | cell_mask[i];
                for (int b = 0; b < BOX; b++) box_seen[b] <= box_next[b];
                dup_acc   <= dup_total;
                blank_acc <= blank_total;
                range_acc <= range_total;
`ifdef CHECKER_CONFLICT_LOC_EN
                if (!conflict_found && row_dup) begin
                    conflict_found   <= 1'b1;
                    conflict_row_acc <= chk_row;
                    conflict_col_acc <= first_col;
                end
`endif
            end

            if (state == S_FLUSH) begin
                done         <= 1'b1;
                gameComplete <= !(dup_total || blank_total || range_total);
                boardValid   <= !dup_total;
`ifdef CHECKER_CONFLICT_LOC_EN
                conflictRow  <= final_row;
                conflictCol  <= final_col;
                conflictHit  <= dup_total;
`endif
            end
        end
    end

endmodule

// File: tb/tb_sudoku_board_checker.sv
// Scoreboard bench for sudoku_board_checker (N=4, BOX=2, DW=4).
// Stimulus pushes the hand-computed result of each scan into a queue; a
// negedge monitor pops and compares whenever done pulses, and also checks
// the start-to-done latency. Conflict-location checks are compiled in when
// CHECKER_CONFLICT_LOC_EN is defined.
module tb_sudoku_board_checker;
    localparam int N     = 4;
    localparam int AW    = 2;
    localparam int RAM_W = 24;
    localparam int LAT   = N + 2;

    typedef struct {
        logic          gc;
        logic          bv;
        logic          hit;
        logic [AW-1:0] crow;
        logic [AW-1:0] ccol;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [AW-1:0]    ram_addr;
    logic [RAM_W-1:0] ram_dat = '0;
    logic             busy, done, game_complete, board_valid;
`ifdef CHECKER_CONFLICT_LOC_EN
    logic [AW-1:0]    conflict_row, conflict_col;
    logic             conflict_hit;
`endif

    logic [RAM_W-1:0] mem [N];
    exp_t             exp_q[$];
    int               launch_q[$];
    int               neg_cnt = 0;
    int               n_checks = 0;
    int               n_fail = 0;

    sudoku_board_checker dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .start        (start),
        .RamAddr      (ram_addr),
        .RamDat       (ram_dat),
        .busy         (busy),
        .done         (done),
        .gameComplete (game_complete),
        .boardValid   (board_valid)
`ifdef CHECKER_CONFLICT_LOC_EN
       ,.conflictRow  (conflict_row),
        .conflictCol  (conflict_col),
        .conflictHit  (conflict_hit)
`endif
    );

    always #5 clk = ~clk;

    // Game RAM model with one cycle of read latency.
    always @(posedge clk) ram_dat <= mem[ram_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [RAM_W-1:0] make_row(input logic [3:0] d0, input logic [3:0] d1,
                                                  input logic [3:0] d2, input logic [3:0] d3,
                                                  input logic [3:0] blank, input logic [3:0] wp);
        return {wp, blank, d3, d2, d1, d0};
    endfunction

    function automatic exp_t mk_exp(input logic gc, input logic bv, input logic hit,
                                    input logic [AW-1:0] crow, input logic [AW-1:0] ccol);
        exp_t e;
        e.gc = gc; e.bv = bv; e.hit = hit; e.crow = crow; e.ccol = ccol;
        return e;
    endfunction

    // Monitor: record accepted starts, compare results on every done pulse.
    always @(negedge clk) begin
        neg_cnt++;
        if (rst_n) begin
            if (start && !busy && !done) launch_q.push_back(neg_cnt);
            if (done) begin
                check("done_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                check("launch_recorded", {31'd0, launch_q.size() != 0}, 32'd1);
                if (launch_q.size() != 0) check("done_latency", neg_cnt - launch_q.pop_front(), LAT);
                check("busy_on_done", {31'd0, busy}, 32'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("gameComplete", {31'd0, game_complete}, {31'd0, e.gc});
                    check("boardValid", {31'd0, board_valid}, {31'd0, e.bv});
`ifdef CHECKER_CONFLICT_LOC_EN
                    check("conflictHit", {31'd0, conflict_hit}, {31'd0, e.hit});
                    check("conflictRow", {30'd0, conflict_row}, {30'd0, e.crow});
                    check("conflictCol", {30'd0, conflict_col}, {30'd0, e.ccol});
`endif
                end
            end
        end
    end

    task automatic load(input logic [RAM_W-1:0] r0, input logic [RAM_W-1:0] r1,
                        input logic [RAM_W-1:0] r2, input logic [RAM_W-1:0] r3);
        mem[0] = r0; mem[1] = r1; mem[2] = r2; mem[3] = r3;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic issue(input exp_t e);
        exp_q.push_back(e);
        pulse_start();
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (!busy && exp_q.size() == 0) break;
        end
        check({name, "_finished"}, {30'd0, busy, exp_q.size() != 0}, 32'd0);
    endtask

    task automatic run(input string name, input exp_t e);
        issue(e);
        wait_idle(name);
        check({name, "_addr_hold"}, {30'd0, ram_addr}, 32'd3);
    endtask

    logic [RAM_W-1:0] s0, s1, s2, s3;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s0 = make_row(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 4'b0000);
        s1 = make_row(4'd3, 4'd4, 4'd1, 4'd2, 4'b0000, 4'b0000);
        s2 = make_row(4'd2, 4'd1, 4'd4, 4'd3, 4'b0000, 4'b0000);
        s3 = make_row(4'd4, 4'd3, 4'd2, 4'd1, 4'b0000, 4'b0000);
        load(s0, s1, s2, s3);

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_gc", {31'd0, game_complete}, 32'd0);
        check("reset_bv", {31'd0, board_valid}, 32'd0);
        check("reset_addr", {30'd0, ram_addr}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1: solved board.
        run("solved", mk_exp(1, 1, 0, 2'd0, 2'd0));

        // 2: row1 col2 blank.
        load(s0, make_row(4'd3, 4'd4, 4'd1, 4'd2, 4'b0100, 4'b0000), s2, s3);
        run("blank", mk_exp(0, 1, 0, 2'd0, 2'd0));

        // 3: column duplicates in col2 and col3 on row3.
        load(s0, s1, s2, make_row(4'd4, 4'd3, 4'd1, 4'd2, 4'b0000, 4'b0000));
        run("col_dup", mk_exp(0, 0, 1, 2'd3, 2'd2));

        // 4: out-of-range digit 5 at row2 col0.
        load(s0, s1, make_row(4'd5, 4'd1, 4'd4, 4'd3, 4'b0000, 4'b0000), s3);
        run("range5", mk_exp(0, 1, 0, 2'd0, 2'd0));

        // 5: rows and columns clean, box0 holds 1,2,2,1.
        load(s0, make_row(4'd2, 4'd1, 4'd4, 4'd3, 4'b0000, 4'b0000),
             make_row(4'd3, 4'd4, 4'd1, 4'd2, 4'b0000, 4'b0000), s3);
        run("box_dup", mk_exp(0, 0, 1, 2'd1, 2'd0));

        // Row duplicate in row0 (1,1,3,4): first hit is row0 col1.
        load(make_row(4'd1, 4'd1, 4'd3, 4'd4, 4'b0000, 4'b0000), s1, s2, s3);
        run("row_dup", mk_exp(0, 0, 1, 2'd0, 2'd1));

        // Digit 0 with blank clear is a range error, not a duplicate.
        load(s0, s1, s2, make_row(4'd4, 4'd3, 4'd2, 4'd0, 4'b0000, 4'b0000));
        run("range0", mk_exp(0, 1, 0, 2'd0, 2'd0));

        // Fully blank board (digits left as garbage): legal but incomplete.
        load(make_row(4'd1, 4'd1, 4'd9, 4'd0, 4'b1111, 4'b0000),
             make_row(4'd1, 4'd1, 4'd1, 4'd1, 4'b1111, 4'b0000),
             make_row(4'd2, 4'd2, 4'd2, 4'd2, 4'b1111, 4'b0000),
             make_row(4'd0, 4'd0, 4'd0, 4'd0, 4'b1111, 4'b0000));
        run("all_blank", mk_exp(0, 1, 0, 2'd0, 2'd0));

        // Solved board with write-protect bits set: no effect on the result.
        load(make_row(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 4'b1111),
             make_row(4'd3, 4'd4, 4'd1, 4'd2, 4'b0000, 4'b1010),
             make_row(4'd2, 4'd1, 4'd4, 4'd3, 4'b0000, 4'b0101), s3);
        run("write_protect", mk_exp(1, 1, 0, 2'd0, 2'd0));

        // 6: reset mid-scan aborts with outputs cleared and no stale done.
        load(s0, s1, s2, s3);
        pulse_start();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        launch_q.delete();
        #2;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_gc", {31'd0, game_complete}, 32'd0);
        check("abort_bv", {31'd0, board_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_abort_idle", {31'd0, busy}, 32'd0);

        // Re-issued start completes; a start while busy adds no extra done.
        issue(mk_exp(1, 1, 0, 2'd0, 2'd0));
        @(posedge clk); #1;
        check("busy_mid_scan", {31'd0, busy}, 32'd1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle("restart");
        repeat (10) @(posedge clk);
        #1;
        check("no_extra_scan", {31'd0, busy}, 32'd0);

        // Start coinciding with done is ignored.
        load(s0, s1, s2, make_row(4'd4, 4'd3, 4'd1, 4'd2, 4'b0000, 4'b0000));
        issue(mk_exp(0, 0, 1, 2'd3, 2'd2));
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) break;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_on_done_ignored", {31'd0, busy}, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("still_idle", {31'd0, busy}, 32'd0);
        check("results_held", {30'd0, game_complete, board_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
